// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: opcode and FSM state enums plus the
// wait-counter width.
package alu_seq_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_EQ  = 3'b100,
    OP_GT  = 3'b101,
    OP_LT  = 3'b110,
    OP_ILL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bundle of the ALU sequencer.
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. The
// producer holds its payload stable while its valid is high and unaccepted.
interface alu_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag;
  logic        err;
  logic [7:0]  op_count;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag, err, op_count
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag, err, op_count
  );
endinterface

// File: rtl/alu_datapath.sv
// Combinational arithmetic/compare unit working on the latched operands.
// The divider exists only when ALU_SEQUENCER_DIV_EN is defined; otherwise
// DIV is reported as an illegal opcode.
module alu_datapath
  import alu_seq_pkg::*;
(
  input  op_t         op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] result,
  output logic        flag,
  output logic        err
);

  logic [8:0]  sum;
  logic [15:0] prod;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = {8'h00, a} * {8'h00, b};

  // Select the operation result; err covers illegal/disabled ops and /0.
  always_comb begin
    result = 16'h0000;
    flag   = 1'b0;
    err    = 1'b0;
    case (op)
      OP_ADD: begin
        result = {8'h00, sum[7:0]};
        flag   = sum[8];
      end
      OP_SUB: begin
        result = {8'h00, a - b};
        flag   = (a < b);
      end
      OP_MUL: result = prod;
`ifdef ALU_SEQUENCER_DIV_EN
      OP_DIV: begin
        if (b == 8'h00) err = 1'b1;
        else            result = {a % b, a / b};
      end
`endif
      OP_EQ: begin
        flag   = (a == b);
        result = {15'b0, flag};
      end
      OP_GT: begin
        flag   = (a > b);
        result = {15'b0, flag};
      end
      OP_LT: begin
        flag   = (a < b);
        result = {15'b0, flag};
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: accepts one request, waits an opcode-dependent
// number of cycles, then holds the result until the consumer takes it.
// Optional divider: define ALU_SEQUENCER_DIV_EN (DIV_WAIT only matters then).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_WAIT = 2,
  parameter int DIV_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_sequencer_if.slave    bus,
  output state_t            fsm_state
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_WAIT - 1);
`ifdef ALU_SEQUENCER_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_WAIT - 1);
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  op_t              op_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [15:0]      result_q;
  logic             flag_q;
  logic             err_q;
  logic [7:0]       count_q;

  logic [15:0]      dp_result;
  logic             dp_flag;
  logic             dp_err;

  // Counter preload is N-1 so DONE is reached exactly N edges after accept.
  function automatic logic [CNT_W-1:0] wait_load(input op_t o);
    case (o)
      OP_MUL:  return MUL_LOAD;
`ifdef ALU_SEQUENCER_DIV_EN
      OP_DIV:  return DIV_LOAD;
`endif
      default: return '0;
    endcase
  endfunction

  alu_datapath u_datapath (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (dp_result),
    .flag   (dp_flag),
    .err    (dp_err)
  );

  // Sequencer FSM: latch request, count down, register result, await take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= OP_ADD;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 16'h0000;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= op_t'(bus.op);
            a_q   <= bus.a;
            b_q   <= bus.b;
            cnt   <= wait_load(op_t'(bus.op));
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            result_q <= dp_result;
            flag_q   <= dp_flag;
            err_q    <= dp_err;
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            count_q <= count_q + 8'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.flag      = flag_q;
  assign bus.err       = err_q;
  assign bus.op_count  = count_q;
  assign fsm_state     = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with hand-computed expected values.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic   clk;
  logic   rst;
  state_t fsm_state;
  int     total;
  int     bad;
  int     exp_count;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: issue one request and count edges until out_valid appears.
  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input bit zero_b_after, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 3'b000;
    bus.a        = 8'h00;
    if (zero_b_after) bus.b = 8'h00;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Driver: complete the result handshake.
  task automatic take_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.flag, bus.err} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 1000", {bus.in_ready, bus.out_valid, bus.flag, bus.err});
    end
    total++;
    if (bus.result !== 16'h0000 || bus.op_count !== 8'h00 || fsm_state !== IDLE) begin
      bad++;
      $display("FAIL reset_data: result=%h count=%0d state=%0d want 0000/0/IDLE",
               bus.result, bus.op_count, fsm_state);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_add();
    int lat;
    run_op(3'b000, 8'hF0, 8'h20, 1'b0, lat);
    total++;
    if (lat !== 1 || bus.result !== 16'h0010 || bus.flag !== 1'b1 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL add_carry: lat=%0d res=%h flag=%b err=%b want 1 0010 1 0", lat, bus.result, bus.flag, bus.err);
    end
    take_result();
    run_op(3'b000, 8'h01, 8'h02, 1'b0, lat);
    total++;
    if (lat !== 1 || bus.result !== 16'h0003 || bus.flag !== 1'b0) begin
      bad++;
      $display("FAIL add_plain: lat=%0d res=%h flag=%b want 1 0003 0", lat, bus.result, bus.flag);
    end
    take_result();
  endtask

  task automatic test_sub_hold();
    int lat;
    run_op(3'b001, 8'd3, 8'd5, 1'b0, lat);
    total++;
    if (lat !== 1 || bus.result !== 16'h00FE || bus.flag !== 1'b1 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL sub_borrow: lat=%0d res=%h flag=%b err=%b want 1 00FE 1 0", lat, bus.result, bus.flag, bus.err);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      bus.op       = 3'b000;
      bus.a        = 8'h11;
      bus.b        = 8'h22;
      total++;
      if (bus.result !== 16'h00FE || {bus.out_valid, bus.in_ready, bus.flag} !== 3'b101 ||
          bus.op_count !== 8'(exp_count)) begin
        bad++;
        $display("FAIL sub_hold[%0d]: res=%h ov/ir/flag=%b count=%0d want 00FE 101 %0d",
                 i, bus.result, {bus.out_valid, bus.in_ready, bus.flag}, bus.op_count, exp_count);
      end
    end
    bus.in_valid = 1'b0;
    take_result();
    total++;
    if (bus.op_count !== 8'(exp_count) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL sub_handshake: count=%0d ov=%b ir=%b want %0d 0 1", bus.op_count, bus.out_valid, bus.in_ready, exp_count);
    end
  endtask

  task automatic test_mul();
    int lat;
    run_op(3'b010, 8'hFF, 8'hFF, 1'b1, lat);
    total++;
    if (lat !== 2 || bus.result !== 16'hFE01 || bus.flag !== 1'b0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL mul_max: lat=%0d res=%h flag=%b err=%b want 2 FE01 0 0", lat, bus.result, bus.flag, bus.err);
    end
    take_result();
    run_op(3'b010, 8'h0C, 8'h00, 1'b0, lat);
    total++;
    if (lat !== 2 || bus.result !== 16'h0000 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL mul_zero: lat=%0d res=%h err=%b want 2 0000 0", lat, bus.result, bus.err);
    end
    take_result();
  endtask

  task automatic test_div();
    int lat;
`ifdef ALU_SEQUENCER_DIV_EN
    run_op(3'b011, 8'd100, 8'd7, 1'b0, lat);
    total++;
    if (lat !== 4 || bus.result !== 16'h020E || bus.flag !== 1'b0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL div_100_7: lat=%0d res=%h flag=%b err=%b want 4 020E 0 0", lat, bus.result, bus.flag, bus.err);
    end
    take_result();
    run_op(3'b011, 8'd100, 8'd0, 1'b0, lat);
    total++;
    if (lat !== 4 || bus.result !== 16'h0000 || bus.err !== 1'b1) begin
      bad++;
      $display("FAIL div_zero: lat=%0d res=%h err=%b want 4 0000 1", lat, bus.result, bus.err);
    end
    take_result();
`else
    run_op(3'b011, 8'd100, 8'd7, 1'b0, lat);
    total++;
    if (lat !== 1 || bus.result !== 16'h0000 || bus.flag !== 1'b0 || bus.err !== 1'b1) begin
      bad++;
      $display("FAIL div_disabled: lat=%0d res=%h flag=%b err=%b want 1 0000 0 1", lat, bus.result, bus.flag, bus.err);
    end
    take_result();
`endif
  endtask

  task automatic test_compare();
    int lat;
    logic [2:0] ops   [3] = '{3'b100, 3'b101, 3'b110};
    logic [7:0] xs    [3] = '{8'd5, 8'd3, 8'd3};
    logic [7:0] ys    [3] = '{8'd5, 8'd9, 8'd9};
    logic       flags [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], xs[i], ys[i], 1'b0, lat);
      total++;
      if (lat !== 1 || bus.flag !== flags[i] || bus.result !== {15'b0, flags[i]} || bus.err !== 1'b0) begin
        bad++;
        $display("FAIL compare[%0d]: lat=%0d res=%h flag=%b err=%b want 1 flag=%b err=0",
                 i, lat, bus.result, bus.flag, bus.err, flags[i]);
      end
      take_result();
    end
  endtask

  task automatic test_illegal();
    int lat;
    run_op(3'b111, 8'hAA, 8'h55, 1'b0, lat);
    total++;
    if (lat !== 1 || bus.result !== 16'h0000 || bus.flag !== 1'b0 || bus.err !== 1'b1) begin
      bad++;
      $display("FAIL illegal: lat=%0d res=%h flag=%b err=%b want 1 0000 0 1", lat, bus.result, bus.flag, bus.err);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    // Leave a non-zero result registered first so reset clearing is visible.
    run_op(3'b010, 8'h10, 8'h10, 1'b0, lat);
    take_result();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 3'b010;
    bus.a        = 8'h33;
    bus.b        = 8'h44;
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.flag, bus.err} !== 4'b1000 ||
        bus.result !== 16'h0000 || bus.op_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_exec: ir/ov/flag/err=%b res=%h count=%0d want 1000 0000 0",
               {bus.in_ready, bus.out_valid, bus.flag, bus.err}, bus.result, bus.op_count);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.op_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_abandon: ov=%b count=%0d want 0 0", bus.out_valid, bus.op_count);
    end
  endtask

  task automatic test_wrap();
    int lat;
    int lat_bad;
    lat_bad = 0;
    for (int i = 0; i < 256; i++) begin
      run_op(3'b110, 8'd1, 8'd2, 1'b0, lat);
      if (lat != 1) lat_bad++;
      take_result();
      if (i == 254) begin
        total++;
        if (bus.op_count !== 8'd255) begin
          bad++;
          $display("FAIL count_255: got %0d want 255", bus.op_count);
        end
      end
    end
    total++;
    if (bus.op_count !== 8'd0 || exp_count != 0) begin
      bad++;
      $display("FAIL count_wrap: got %0d want 0", bus.op_count);
    end
    total++;
    if (lat_bad !== 0) begin
      bad++;
      $display("FAIL wrap_latency: %0d ops with latency != 1, want 0", lat_bad);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    exp_count     = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_hold();
    test_mul();
    test_div();
    test_compare();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MUL_WAIT, default 2, execute cycles for MUL (legal 1..15).
REQ-002 Parameter DIV_WAIT, default 4, execute cycles for DIV (legal 1..15).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  request present.
REQ-006 Port in_ready  output  1  sequencer can accept a request.
REQ-007 Port op  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 EQ, 101 GT, 110 LT, 111 illegal.
REQ-008 Port a, b  input  8 each  operands.
REQ-009 Port out_valid  output  1  result held and valid.
REQ-010 Port out_ready  input  1  consumer takes result.
REQ-011 Port result  output  16  operation result.
REQ-012 Port flag  output  1  carry/borrow/compare outcome.
REQ-013 Port err  output  1  divide-by-zero or illegal/disabled opcode.
REQ-014 Port op_count  output  8  completed operations, wraps 255->0.

Function
REQ-015 FSM SHALL have states IDLE, EXEC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 Accept SHALL occur on an edge with in_valid && in_ready; op, a, b are latched then and later input changes do not affect the result.
REQ-017 On accept, FSM SHALL enter EXEC with a 4-bit wait counter loaded to N-1, N = 1 (ADD, SUB, EQ, GT, LT, illegal), MUL_WAIT (MUL), DIV_WAIT (DIV).
REQ-018 In EXEC the counter SHALL decrement each cycle; on the edge where it is 0, result/flag/err are registered and FSM enters DONE, so out_valid rises exactly N edges after the accepting edge.
REQ-019 DONE SHALL hold result, flag, err stable until an edge with out_ready=1, then return to IDLE and increment op_count.
REQ-020 in_valid outside IDLE and out_ready outside DONE SHALL be ignored; a new request is accepted no earlier than the edge after the DONE handshake.
REQ-021 ADD: result = {8'h00, (a+b) mod 256}, flag = carry out of bit 7.
REQ-022 SUB: result = {8'h00, (a-b) mod 256}, flag = borrow (a<b).
REQ-023 MUL: result = a*b full 16 bits, flag = 0; b=0 gives 16'h0000.
REQ-024 DIV: result = {a%b, a/b} (remainder high byte, quotient low byte), flag = 0; b=0 gives result 0, err=1.
REQ-025 EQ/GT/LT: flag = (a==b)/(a>b)/(a<b) unsigned, result = {15'b0, flag}.
REQ-026 Illegal opcode SHALL give result 0, flag 0, err 1, latency 1.
REQ-027 err SHALL be 0 for every other completed operation.

Reset
REQ-028 rst SHALL asynchronously force state IDLE, counter 0, result 16'h0000, flag 0, err 0, op_count 0, hence in_ready 1, out_valid 0.
REQ-029 rst during EXEC or DONE SHALL abandon the operation with no result delivered and op_count unchanged from 0.

Configuration
REQ-030 Macro ALU_SEQUENCER_DIV_EN defined: DIV implemented per REQ-017/024.
REQ-031 Macro undefined: no divider logic; opcode 011 behaves as illegal per REQ-026; DIV_WAIT unused.

Structure
REQ-032 Shared package alu_seq_pkg SHALL hold the opcode enum, FSM state enum, and the 4-bit wait-counter width constant.
REQ-033 One sub-module alu_datapath SHALL hold all combinational arithmetic/compare logic from latched op, a, b; alu_sequencer holds FSM, counter, output registers.

Verification
REQ-034 ADD a=8'hF0 b=8'h20, out_ready=1 -> out_valid 1 edge after accept, result 16'h0010, flag 1, err 0.
REQ-035 MUL a=8'hFF b=8'hFF, MUL_WAIT=2 -> out_valid 2 edges after accept, result 16'hFE01; b changed to 0 after accept has no effect.
REQ-036 DIV a=8'd100 b=8'd7 -> after DIV_WAIT=4 edges result 16'h020E; then DIV b=0 -> result 0, err 1; without macro DIV a=100 b=7 -> err 1, latency 1.
REQ-037 SUB a=3 b=5 with out_ready=0 for 5 cycles -> result 16'h00FE, flag 1 held stable, in_ready 0, in_valid pulses ignored; op_count increments only at handshake.
REQ-038 rst asserted mid-EXEC of MUL -> immediately in_ready 1, out_valid 0, outputs 0; 256 LT ops complete -> op_count wraps to 0.
